// File: rtl/pid_seq.sv
// pid_seq: sequential PID controller. One shared signed multiplier is stepped over
// the P, I and D terms by a five-state FSM. The output is an unsigned saturated
// stimulus with a one-cycle out_valid pulse. The integrator clamps and has
// conditional-integration anti-windup.
module pid_seq #(
    parameter int BITS  = 8,
    parameter int IBITS = BITS + 4,
    parameter int FRAC  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pv_stb,
    input  logic [BITS-1:0] sp,
    input  logic [BITS-1:0] pv,
    input  logic [BITS-1:0] kp,
    input  logic [BITS-1:0] ki,
    input  logic [BITS-1:0] kd,
    output logic            busy,
    output logic            out_valid,
    output logic [BITS-1:0] stimulus
);

    // Widths: error, derivative, multiplier operand, gain, product, accumulator.
    localparam int EW   = BITS + 1;
    localparam int DW   = BITS + 2;
    localparam int OW   = (IBITS > DW) ? IBITS : DW;
    localparam int GW   = BITS + 1;
    localparam int PW   = GW + OW;
    localparam int ACCW = IBITS + BITS + 3;

    // The integrator range is symmetric, so IMIN is -IMAX and not the most negative code.
    localparam int IMAX_I = (1 << (IBITS - 1)) - 1;
    localparam logic signed [IBITS-1:0] IMAX   = IBITS'(IMAX_I);
    localparam logic signed [IBITS-1:0] IMIN   = IBITS'(-IMAX_I);
    localparam logic signed [IBITS:0]   IMAX_X = (IBITS + 1)'(IMAX_I);
    localparam logic signed [IBITS:0]   IMIN_X = (IBITS + 1)'(-IMAX_I);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_P,
        S_MUL_I,
        S_MUL_D,
        S_SUM
    } state_t;

    state_t                  state_q;
    logic [BITS-1:0]         kp_q, ki_q, kd_q;
    logic signed [EW-1:0]    e_q, e_prev_q;
    logic signed [DW-1:0]    d_q;
    logic signed [IBITS-1:0] integ_q;
    logic                    first_q;
    logic                    sat_hi_q, sat_lo_q;
    logic signed [ACCW-1:0]  acc_q;
    logic [BITS-1:0]         stimulus_q;
    logic                    out_valid_q, busy_q;

    logic signed [EW-1:0]    e_d;
    logic signed [DW-1:0]    d_d;
    logic signed [IBITS:0]   integ_sum;
    logic signed [IBITS-1:0] integ_d;
    logic                    freeze;
    logic signed [GW-1:0]    mul_a;
    logic signed [OW-1:0]    mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  r;
    logic                    r_hi, r_lo;
    logic [BITS-1:0]         stim_d;

    // Compute the new error, derivative and clamped integrator from the live inputs.
    // These values are captured only on an accepted strobe.
    always_comb begin
        e_d       = $signed({1'b0, sp}) - $signed({1'b0, pv});
        d_d       = first_q ? '0 : (DW'(e_d) - DW'(e_prev_q));
        integ_sum = (IBITS + 1)'(integ_q) + (IBITS + 1)'(e_d);
        if (integ_sum > IMAX_X) begin
            integ_d = IMAX;
        end else if (integ_sum < IMIN_X) begin
            integ_d = IMIN;
        end else begin
            integ_d = integ_sum[IBITS-1:0];
        end
        // Do not integrate further in the direction the output is already saturated.
        freeze = (sat_hi_q && !e_d[EW-1] && (e_d != '0)) || (sat_lo_q && e_d[EW-1]);
    end

    // Shared multiplier: the FSM state selects the zero-extended gain and the signed operand.
    always_comb begin
        mul_a = $signed({1'b0, kp_q});
        mul_b = OW'(e_q);
        case (state_q)
            S_MUL_I: begin
                mul_a = $signed({1'b0, ki_q});
                mul_b = OW'(integ_q);
            end
            S_MUL_D: begin
                mul_a = $signed({1'b0, kd_q});
                mul_b = OW'(d_q);
            end
            default: ;
        endcase
        prod = PW'(mul_a) * PW'(mul_b);
    end

    // Scale the sum of terms down and saturate it into the unsigned output range.
    always_comb begin
        r      = acc_q >>> FRAC;
        r_lo   = r[ACCW-1];
        r_hi   = !r[ACCW-1] && (|r[ACCW-2:BITS]);
        stim_d = r_lo ? '0 : (r_hi ? '1 : r[BITS-1:0]);
    end

    // Control FSM with registered outputs.
    // A strobe is accepted only in IDLE, so a strobe that arrives while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            e_q         <= '0;
            e_prev_q    <= '0;
            d_q         <= '0;
            integ_q     <= '0;
            first_q     <= 1'b1;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            acc_q       <= '0;
            stimulus_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pv_stb) begin
                        kp_q     <= kp;
                        ki_q     <= ki;
                        kd_q     <= kd;
                        e_q      <= e_d;
                        d_q      <= d_d;
                        e_prev_q <= e_d;
                        first_q  <= 1'b0;
                        if (!freeze) begin
                            integ_q <= integ_d;
                        end
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MUL_P;
                    end
                end
                S_MUL_P: begin
                    acc_q   <= acc_q + ACCW'(prod);
                    state_q <= S_MUL_I;
                end
                S_MUL_I: begin
                    acc_q   <= acc_q + ACCW'(prod);
                    state_q <= S_MUL_D;
                end
                S_MUL_D: begin
                    acc_q   <= acc_q + ACCW'(prod);
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    stimulus_q  <= stim_d;
                    sat_hi_q    <= r_hi;
                    sat_lo_q    <= r_lo;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign stimulus  = stimulus_q;

endmodule

// File: tb/tb_pid_seq.sv
// Directed testbench for pid_seq. It drives a default instance and a second
// instance with a 10-bit integrator for the windup and clamp cases.
module tb_pid_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pv_stb = 1'b0;
    logic [7:0] sp = '0, pv = '0, kp = '0, ki = '0, kd = '0;
    logic       busy, out_valid, busy_w, ov_w;
    logic [7:0] stimulus, stim_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pid_seq dut (
        .clk(clk), .reset(reset), .pv_stb(pv_stb),
        .sp(sp), .pv(pv), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy), .out_valid(out_valid), .stimulus(stimulus)
    );

    pid_seq #(.BITS(8), .IBITS(10), .FRAC(4)) dut_w (
        .clk(clk), .reset(reset), .pv_stb(pv_stb),
        .sp(sp), .pv(pv), .kp(kp), .ki(ki), .kd(kd),
        .busy(busy_w), .out_valid(ov_w), .stimulus(stim_w)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset  = 1'b1;
        pv_stb = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    // One strobe. The inputs are scrambled while busy, then latency and result are checked.
    task automatic do_sample(input string tag, input logic [7:0] s, input logic [7:0] p,
                             input logic [7:0] gp, input logic [7:0] gi_, input logic [7:0] gd,
                             input int exp_stim);
        int lat;
        @(negedge clk);
        sp = s; pv = p; kp = gp; ki = gi_; kd = gd; pv_stb = 1'b1;
        @(posedge clk);
        #1;
        pv_stb = 1'b0;
        sp = ~s; pv = ~p; kp = ~gp; ki = ~gi_; kd = ~gd;
        lat = 1;
        check({tag, " busy"}, int'(busy), 1);
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " stimulus"}, int'(stimulus), exp_stim);
        check({tag, " busy_done"}, int'(busy), 0);
    endtask

    initial begin
        int cnt;
        int last;
        int busy_at4;
        int stim_at4;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset stimulus", int'(stimulus), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);

        // Proportional term only, then both saturation limits.
        do_sample("p_only", 8'd100, 8'd40, 8'd16, 8'd0, 8'd0, 60);
        do_sample("clamp_lo", 8'd10, 8'd200, 8'd16, 8'd0, 8'd0, 0);
        do_sample("clamp_hi", 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 255);

        // Integral term.
        reset_dut();
        do_sample("i1", 8'd50, 8'd40, 8'd0, 8'd16, 8'd0, 10);
        do_sample("i2", 8'd50, 8'd40, 8'd0, 8'd16, 8'd0, 20);
        do_sample("i3", 8'd50, 8'd40, 8'd0, 8'd16, 8'd0, 30);

        // Derivative term. The first sample after reset has d=0.
        reset_dut();
        do_sample("d1", 8'd10, 8'd0, 8'd0, 8'd0, 8'd16, 0);
        do_sample("d2", 8'd30, 8'd0, 8'd0, 8'd0, 8'd16, 20);
        do_sample("d3", 8'd30, 8'd0, 8'd0, 8'd0, 8'd16, 0);
        do_sample("d4_neg", 8'd5, 8'd0, 8'd0, 8'd0, 8'd16, 0);

        // All three terms together: 20+20+0, 20+40+0, 30+70+10; then 8*7/16 truncates to 3.
        reset_dut();
        do_sample("pid1", 8'd20, 8'd0, 8'd16, 8'd16, 8'd16, 40);
        do_sample("pid2", 8'd20, 8'd0, 8'd16, 8'd16, 8'd16, 60);
        do_sample("pid3", 8'd30, 8'd0, 8'd16, 8'd16, 8'd16, 110);
        do_sample("frac", 8'd7, 8'd0, 8'd8, 8'd0, 8'd0, 3);

        // Windup: the 10-bit integrator clamps at 511; the 12-bit one shows the freeze.
        reset_dut();
        do_sample("w1", 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0);
        check("w1 integ_w", int'(dut_w.integ_q), 255);
        do_sample("w2", 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0);
        check("w2 integ_w", int'(dut_w.integ_q), 510);
        do_sample("w3", 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0);
        check("w3 integ_w", int'(dut_w.integ_q), 511);
        check("w3 integ", int'(dut.integ_q), 765);
        do_sample("w4", 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 255);
        check("w4 integ_w", int'(dut_w.integ_q), 511);
        check("w4 integ", int'(dut.integ_q), 1020);
        do_sample("w5_frz_hi", 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 255);
        check("w5 integ_w", int'(dut_w.integ_q), 511);
        check("w5 integ", int'(dut.integ_q), 1020);
        do_sample("w6", 8'd0, 8'd255, 8'd16, 8'd0, 8'd0, 0);
        check("w6 integ_w", int'(dut_w.integ_q), 256);
        check("w6 integ", int'(dut.integ_q), 765);
        do_sample("w7_frz_lo", 8'd0, 8'd255, 8'd16, 8'd0, 8'd0, 0);
        check("w7 integ_w", int'(dut_w.integ_q), 256);
        check("w7 integ", int'(dut.integ_q), 765);
        do_sample("w8", 8'd10, 8'd0, 8'd16, 8'd0, 8'd0, 10);
        check("w8 integ_w", int'(dut_w.integ_q), 266);
        check("w8 integ", int'(dut.integ_q), 775);

        // Negative integrator clamp at -511.
        reset_dut();
        do_sample("n1", 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 0);
        check("n1 integ_w", int'(dut_w.integ_q), -255);
        do_sample("n2", 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 0);
        check("n2 integ_w", int'(dut_w.integ_q), -510);
        do_sample("n3", 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 0);
        check("n3 integ_w", int'(dut_w.integ_q), -511);
        check("n3 integ", int'(dut.integ_q), -765);

        // Handshake: a second strobe in cycle 2 while busy is ignored.
        reset_dut();
        @(negedge clk);
        sp = 8'd100; pv = 8'd40; kp = 8'd16; ki = 8'd0; kd = 8'd0; pv_stb = 1'b1;
        cnt = 0;
        last = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            pv_stb = (c == 2);
            if (c == 2) begin
                sp = 8'd200; pv = 8'd0; kp = 8'd255;
            end
            if (out_valid) begin
                cnt++;
                last = c;
            end
        end
        check("hs out_valid count", cnt, 1);
        check("hs out_valid cycle", last, 5);
        check("hs stimulus", int'(stimulus), 60);

        // Reset in cycle 3 aborts the computation.
        @(negedge clk);
        sp = 8'd255; pv = 8'd0; kp = 8'd255; pv_stb = 1'b1;
        cnt = 0;
        busy_at4 = -1;
        stim_at4 = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            pv_stb = 1'b0;
            if (c == 4) begin
                busy_at4 = int'(busy);
                stim_at4 = int'(stimulus);
            end
            reset = (c == 3);
            if (out_valid) cnt++;
        end
        check("abort out_valid count", cnt, 0);
        check("abort busy c4", busy_at4, 0);
        check("abort stimulus c4", stim_at4, 0);
        check("abort stimulus end", int'(stimulus), 0);
        check("abort busy end", int'(busy), 0);

        // Operation after the abort; first_q was set again by the reset, so d=0.
        do_sample("post_abort", 8'd100, 8'd40, 8'd16, 8'd0, 8'd16, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
